// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// FSM state codes, ALU control codes and the FSM-to-ALU-decoder aluop type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flag in, selects and enables out.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );

  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );
endinterface

// File: rtl/mips_aludec.sv
// ALU control decoder: aluop from the FSM plus funct from IR -> ALU operation.
module mips_aludec
  import mips_pkg::*;
(
  input  aluop_t     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       bad_funct_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    bad_funct_o  = 1'b0;
    case (aluop_i)
      ALUOP_SUB:   alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          default: bad_funct_o  = 1'b1;
        endcase
      end
      default:     alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: Moore state outputs plus the
// zero-qualified PC enable and the ALU decoder.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input logic             clk,
  input logic             reset,
  mips_multicycle_ctrl_if.master bus
);

  state_t     state_q, state_d;
  aluop_t     aluop;
  logic       pcwrite, branch, irwrite, memwrite, regwrite;
  logic       bad_op, bad_funct;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = S_FETCH;
    aluop        = ALUOP_ADD;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    irwrite      = 1'b0;
    memwrite     = 1'b0;
    regwrite     = 1'b0;
    bad_op       = 1'b0;
    bus.iord     = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    case (state_q)
      S_FETCH: begin
        bus.alusrcb = 2'b01;
        irwrite     = 1'b1;
        pcwrite     = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // branch target is precomputed here so BEQEX only needs the compare
        bus.alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            state_d = S_FETCH;
            bad_op  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.iord = 1'b1;
        state_d  = S_MEMWB;
      end
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        regwrite     = 1'b1;
      end
      S_MEMWR: begin
        bus.iord = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_FUNCT;
        state_d     = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        bus.regdst = 1'b1;
        regwrite   = 1'b1;
      end
      S_BEQEX: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_SUB;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
      end
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  mips_aludec u_aludec (
    .aluop_i      (aluop),
    .funct_i      (bus.funct),
    .alucontrol_o (bus.alucontrol),
    .bad_funct_o  (bad_funct)
  );

  // Reset holds state at FETCH, whose strobes must not fire until release.
  assign bus.pcen     = ~reset & (pcwrite | (branch & bus.zero));
  assign bus.irwrite  = ~reset & irwrite;
  assign bus.memwrite = ~reset & memwrite;
  assign bus.regwrite = ~reset & regwrite;
  assign bus.illegal  = ~reset & (bad_op | ((state_q == S_RTYPEEX) & bad_funct));
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle MIPS controller: walks each instruction
// class through its states and checks every output against hand-derived values.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b1;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  mips_multicycle_ctrl_if bus_if ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ck(input string tag, input logic [3:0] st,
                    input logic pcen, input logic iord, input logic mw,
                    input logic irw, input logic rdst, input logic m2r,
                    input logic rw, input logic asa, input logic [1:0] asb,
                    input logic [1:0] pcs, input logic [2:0] alu,
                    input logic ill);
    logic [19:0] obs, exp;
    obs = {bus_if.state, bus_if.pcen, bus_if.iord, bus_if.memwrite,
           bus_if.irwrite, bus_if.regdst, bus_if.memtoreg, bus_if.regwrite,
           bus_if.alusrca, bus_if.alusrcb, bus_if.pcsrc, bus_if.alucontrol,
           bus_if.illegal};
    exp = {st, pcen, iord, mw, irw, rdst, m2r, rw, asa, asb, pcs, alu, ill};
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // field order: st pcen iord mw irw rdst m2r rw asa asb pcs alu ill
  task automatic ck_fetch(input string tag);
    ck(tag, 4'd0, 1,0,0,1,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
  endtask

  task automatic ck_decode(input string tag);
    ck(tag, 4'd1, 0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    bus_if.op    = 6'b100011;
    bus_if.funct = 6'b000000;
    bus_if.zero  = 1'b0;

    #12;
    ck("reset", 4'd0, 0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
    #13 reset = 1'b0;
    #1;
    ck_fetch("lw_fetch");

    // lw: 0,1,2,3,4,0
    tick(); ck_decode("lw_decode");
    tick(); ck("lw_memadr", 4'd2, 0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0);
    tick(); ck("lw_memrd",  4'd3, 0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0);
    tick(); ck("lw_memwb",  4'd4, 0,0,0,0,0,1,1,0, 2'b00, 2'b00, 3'b010, 0);
    tick(); ck_fetch("sw_fetch");

    // sw: 0,1,2,5,0
    bus_if.op = 6'b101011;
    tick(); ck_decode("sw_decode");
    tick(); ck("sw_memadr", 4'd2, 0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0);
    tick(); ck("sw_memwr",  4'd5, 0,1,1,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0);
    tick(); ck_fetch("slt_fetch");

    // R-type slt
    bus_if.op = 6'b000000; bus_if.funct = 6'b101010;
    tick(); ck_decode("slt_decode");
    tick(); ck("slt_ex", 4'd6, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b111, 0);
    tick(); ck("slt_wb", 4'd7, 0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b010, 0);
    tick();

    // R-type sub, and, or
    bus_if.funct = 6'b100010;
    tick(); tick(); ck("sub_ex", 4'd6, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b110, 0);
    tick(); tick();
    bus_if.funct = 6'b100100;
    tick(); tick(); ck("and_ex", 4'd6, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b000, 0);
    tick(); tick();
    bus_if.funct = 6'b100101;
    tick(); tick(); ck("or_ex",  4'd6, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b001, 0);
    tick(); tick();

    // R-type with unsupported funct: illegal in EX, write still happens
    bus_if.funct = 6'b111111;
    tick(); ck_decode("badfn_decode");
    tick(); ck("badfn_ex", 4'd6, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b010, 1);
    tick(); ck("badfn_wb", 4'd7, 0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b010, 0);
    tick(); ck_fetch("addi_fetch");

    // addi
    bus_if.op = 6'b001000; bus_if.funct = 6'b000000;
    tick(); ck_decode("addi_decode");
    tick(); ck("addi_ex", 4'd9,  0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0);
    tick(); ck("addi_wb", 4'd10, 0,0,0,0,0,0,1,0, 2'b00, 2'b00, 3'b010, 0);
    tick(); ck_fetch("beq1_fetch");

    // beq taken
    bus_if.op = 6'b000100; bus_if.zero = 1'b1;
    tick(); ck_decode("beq1_decode");
    tick(); ck("beq1_ex", 4'd8, 1,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110, 0);
    tick(); ck_fetch("beq0_fetch");

    // beq not taken
    bus_if.zero = 1'b0;
    tick(); ck_decode("beq0_decode");
    tick(); ck("beq0_ex", 4'd8, 0,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110, 0);
    tick(); ck_fetch("j_fetch");

    // j
    bus_if.op = 6'b000010;
    tick(); ck_decode("j_decode");
    tick(); ck("j_ex", 4'd11, 1,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b010, 0);
    tick(); ck_fetch("ill_fetch");

    // unsupported opcode: 2 cycles, pulse in DECODE only
    bus_if.op = 6'b111111;
    tick(); ck("ill_decode", 4'd1, 0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 1);
    tick(); ck_fetch("ill_back");

    // asynchronous reset in the middle of MEMWR
    bus_if.op = 6'b101011;
    tick(); tick();
    tick(); ck("arst_memwr", 4'd5, 0,1,1,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0);
    #2 reset = 1'b1;
    #1 ck("arst_now", 4'd0, 0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
    #2 reset = 1'b0;
    #1 ck_fetch("arst_fetch");
    tick(); ck_decode("arst_decode");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
